// File: rtl/tlc_pkg.sv
// Shared lamp encodings, phase codes and lamp decoding for the traffic light controllers.
package tlc_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [1:0] PED_NEITHER = 2'b00;
  localparam logic [1:0] PED_EW      = 2'b01;
  localparam logic [1:0] PED_NS      = 2'b10;
  localparam logic [1:0] PED_BOTH    = 2'b11;

  typedef enum logic [2:0] {
    PH_ALLRED    = 3'd0,
    PH_WALK      = 3'd1,
    PH_NS_GREEN  = 3'd2,
    PH_NS_YELLOW = 3'd3,
    PH_EW_GREEN  = 3'd4,
    PH_EW_YELLOW = 3'd5
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic [1:0] ped;
  } lamps_t;

  // Unknown phase codes fall back to the safe all-red, no-walk pattern.
  function automatic lamps_t decode_lamps(input logic [2:0] ph);
    lamps_t l;
    case (ph)
      3'd0:    l = '{ns: LIGHT_RED,    ew: LIGHT_RED,    ped: PED_NEITHER};
      3'd1:    l = '{ns: LIGHT_RED,    ew: LIGHT_RED,    ped: PED_BOTH};
      3'd2:    l = '{ns: LIGHT_GREEN,  ew: LIGHT_RED,    ped: PED_NS};
      3'd3:    l = '{ns: LIGHT_YELLOW, ew: LIGHT_RED,    ped: PED_NS};
      3'd4:    l = '{ns: LIGHT_RED,    ew: LIGHT_GREEN,  ped: PED_EW};
      3'd5:    l = '{ns: LIGHT_RED,    ew: LIGHT_YELLOW, ped: PED_EW};
      default: l = '{ns: LIGHT_RED,    ew: LIGHT_RED,    ped: PED_NEITHER};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase down-counter: loads a duration minus one on phase entry, counts to zero, never wraps.
module tlc_phase_timer #(
  parameter int            TW      = 4,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  localparam logic [TW-1:0] ONE = TW'(1);

  logic [TW-1:0] r_cnt;

  // Count register: load wins over decrement, saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= RST_VAL;
    end else if (clk_en) begin
      if (load) begin
        r_cnt <= load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - ONE;
      end
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/tlc_param.sv
// Parametrised NS/EW traffic light controller with pedestrian scramble, all-red clearance
// and demand-driven green rest; the internal phase timer advances only on clk_en ticks.
module tlc_param
  import tlc_pkg::*;
#(
  parameter int TW       = 4,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 15,
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic [1:0] light_ped,
  output logic [2:0] phase,
  output logic       ped_waiting
);

  localparam int T_MAX = 1 << TW;

  if (T_ALLRED < 1 || T_ALLRED > T_MAX) begin : g_bad_allred
    $error("tlc_param: T_ALLRED out of range for TW");
  end
  if (T_WALK < 1 || T_WALK > T_MAX) begin : g_bad_walk
    $error("tlc_param: T_WALK out of range for TW");
  end
  if (T_GREEN < 1 || T_GREEN > T_MAX) begin : g_bad_green
    $error("tlc_param: T_GREEN out of range for TW");
  end
  if (T_YELLOW < 1 || T_YELLOW > T_MAX) begin : g_bad_yellow
    $error("tlc_param: T_YELLOW out of range for TW");
  end

  localparam logic [TW-1:0] L_ALLRED = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] L_WALK   = TW'(T_WALK - 1);
  localparam logic [TW-1:0] L_GREEN  = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] L_YELLOW = TW'(T_YELLOW - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  dir_t          r_last_dir;
  dir_t          w_sel_dir;
  logic          r_ped_pending;
  logic          w_zero;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_enter_walk;
  lamps_t        w_lamps;

  tlc_phase_timer #(
    .TW      (TW),
    .RST_VAL (L_ALLRED)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  // Direction choice and next-phase logic; a zero count gates every timed exit.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_dir   = (r_last_dir == DIR_EW) ? DIR_NS : DIR_EW;
    if (car_ns && !car_ew) begin
      w_sel_dir = DIR_NS;
    end else if (car_ew && !car_ns) begin
      w_sel_dir = DIR_EW;
    end else begin
      w_sel_dir = (r_last_dir == DIR_EW) ? DIR_NS : DIR_EW;
    end
    if (clk_en) begin
      case (r_state)
        PH_ALLRED: begin
          if (!w_zero) begin
            w_state_nxt = r_state;
          end else if (r_ped_pending) begin
            w_state_nxt = PH_WALK;
          end else if (w_sel_dir == DIR_NS) begin
            w_state_nxt = PH_NS_GREEN;
          end else begin
            w_state_nxt = PH_EW_GREEN;
          end
        end
        PH_WALK: begin
          if (w_zero) w_state_nxt = PH_ALLRED;
          else        w_state_nxt = r_state;
        end
        PH_NS_GREEN: begin
          if (w_zero && (car_ew || r_ped_pending)) w_state_nxt = PH_NS_YELLOW;
          else                                     w_state_nxt = r_state;
        end
        PH_NS_YELLOW: begin
          if (w_zero) w_state_nxt = PH_ALLRED;
          else        w_state_nxt = r_state;
        end
        PH_EW_GREEN: begin
          if (w_zero && (car_ns || r_ped_pending)) w_state_nxt = PH_EW_YELLOW;
          else                                     w_state_nxt = r_state;
        end
        PH_EW_YELLOW: begin
          if (w_zero) w_state_nxt = PH_ALLRED;
          else        w_state_nxt = r_state;
        end
        default: w_state_nxt = PH_ALLRED;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Timer reload on every phase change with the duration of the phase being entered.
  always_comb begin
    w_load       = clk_en && (w_state_nxt != r_state);
    w_enter_walk = w_load && (w_state_nxt == PH_WALK);
    case (w_state_nxt)
      PH_ALLRED:    w_load_val = L_ALLRED;
      PH_WALK:      w_load_val = L_WALK;
      PH_NS_GREEN,
      PH_EW_GREEN:  w_load_val = L_GREEN;
      PH_NS_YELLOW,
      PH_EW_YELLOW: w_load_val = L_YELLOW;
      default:      w_load_val = L_ALLRED;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PH_ALLRED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Last served direction, recorded on entry to a green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_dir <= DIR_EW;
    end else if (w_load && (w_state_nxt == PH_NS_GREEN)) begin
      r_last_dir <= DIR_NS;
    end else if (w_load && (w_state_nxt == PH_EW_GREEN)) begin
      r_last_dir <= DIR_EW;
    end
  end

  // Pedestrian latch samples every clock, not just ticks; entering WALK clears it first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ped_pending <= 1'b1;
    end else if (w_enter_walk) begin
      r_ped_pending <= 1'b0;
    end else if (ped && (r_state != PH_WALK)) begin
      r_ped_pending <= 1'b1;
    end
  end

  // Moore lamp decode from the phase register.
  always_comb begin
    w_lamps = decode_lamps(r_state);
  end

  assign light_ns    = w_lamps.ns;
  assign light_ew    = w_lamps.ew;
  assign light_ped   = w_lamps.ped;
  assign phase       = r_state;
  assign ped_waiting = r_ped_pending;

endmodule

// File: tb/tb_tlc_param.sv
// Directed bench for tlc_param: a vector table for the steady-enable sequence plus
// hand-written sequences for the pedestrian latch, enable gating and async reset.
module tb_tlc_param;
  import tlc_pkg::*;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic       car_ns = 1'b0;
  logic       car_ew = 1'b0;
  logic       ped = 1'b0;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic [1:0] light_ped;
  logic [2:0] phase;
  logic       ped_waiting;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    int         ticks;
    logic       cns;
    logic       cew;
    logic [2:0] ens;
    logic [2:0] eew;
    logic [1:0] eped;
    logic [2:0] eph;
    logic       ewait;
  } vec_t;

  vec_t vecs[26];
  int   n_vec = 0;

  tlc_param dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .car_ns      (car_ns),
    .car_ew      (car_ew),
    .ped         (ped),
    .light_ns    (light_ns),
    .light_ew    (light_ew),
    .light_ped   (light_ped),
    .phase       (phase),
    .ped_waiting (ped_waiting)
  );

  always #5 clk = ~clk;

  task automatic add(input string name, input int ticks, input logic cns, input logic cew,
                     input logic [2:0] ens, input logic [2:0] eew, input logic [1:0] eped,
                     input logic [2:0] eph, input logic ewait);
    vecs[n_vec] = '{name, ticks, cns, cew, ens, eew, eped, eph, ewait};
    n_vec++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic en_tick();
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] ens, input logic [2:0] eew,
                     input logic [1:0] eped, input logic [2:0] eph, input logic ewait);
    n_cmp++;
    if (light_ns !== ens || light_ew !== eew || light_ped !== eped ||
        phase !== eph || ped_waiting !== ewait) begin
      n_bad++;
      $display("FAIL %s: got ns=%b ew=%b ped=%b ph=%0d wait=%b, want ns=%b ew=%b ped=%b ph=%0d wait=%b",
               name, light_ns, light_ew, light_ped, phase, ped_waiting,
               ens, eew, eped, eph, ewait);
    end
  endtask

  initial begin
    add("reset",        0, 0, 0, R, R, 2'b00, 3'd0, 1);
    add("allred_t1",    1, 0, 0, R, R, 2'b00, 3'd0, 1);
    add("walk_entry",   1, 0, 0, R, R, 2'b11, 3'd1, 0);
    add("walk_last",   14, 0, 0, R, R, 2'b11, 3'd1, 0);
    add("allred2_t1",   1, 0, 0, R, R, 2'b00, 3'd0, 0);
    add("allred2_t2",   1, 0, 0, R, R, 2'b00, 3'd0, 0);
    add("ns_green",     1, 0, 0, G, R, 2'b10, 3'd2, 0);
    add("ns_rest",     16, 0, 0, G, R, 2'b10, 3'd2, 0);
    add("ns_yel_dem",   1, 0, 1, Y, R, 2'b10, 3'd3, 0);
    add("ns_yel_last",  3, 0, 1, Y, R, 2'b10, 3'd3, 0);
    add("clr1_t1",      1, 0, 1, R, R, 2'b00, 3'd0, 0);
    add("clr1_t2",      1, 0, 1, R, R, 2'b00, 3'd0, 0);
    add("ew_by_car",    1, 0, 1, R, G, 2'b01, 3'd4, 0);
    add("ew_rest",     10, 0, 1, R, G, 2'b01, 3'd4, 0);
    add("ew_yel_dem",   1, 1, 0, R, Y, 2'b01, 3'd5, 0);
    add("ew_yel_last",  3, 1, 0, R, Y, 2'b01, 3'd5, 0);
    add("clr2_t1",      1, 1, 0, R, R, 2'b00, 3'd0, 0);
    add("clr2_t2",      1, 1, 0, R, R, 2'b00, 3'd0, 0);
    add("ns_by_car",    1, 1, 0, G, R, 2'b10, 3'd2, 0);
    add("ns_min_a",     3, 0, 0, G, R, 2'b10, 3'd2, 0);
    add("ns_min_t10",   6, 0, 1, G, R, 2'b10, 3'd2, 0);
    add("ns_min_end",   1, 0, 1, Y, R, 2'b10, 3'd3, 0);
    add("clr3_t1",      4, 0, 0, R, R, 2'b00, 3'd0, 0);
    add("clr3_t2",      1, 0, 0, R, R, 2'b00, 3'd0, 0);
    add("tie_to_ew",    1, 0, 0, R, G, 2'b01, 3'd4, 0);
    add("ew_rest2",    20, 0, 0, R, G, 2'b01, 3'd4, 0);

    #12 rst = 1'b0;
    #1;
    for (int i = 0; i < n_vec; i++) begin
      car_ns = vecs[i].cns;
      car_ew = vecs[i].cew;
      step(vecs[i].ticks);
      chk(vecs[i].name, vecs[i].ens, vecs[i].eew, vecs[i].eped, vecs[i].eph, vecs[i].ewait);
    end

    // Pedestrian pulse on a disabled edge while resting in EW green.
    clk_en = 1'b0;
    ped = 1'b1;
    step(1);
    ped = 1'b0;
    chk("ped_latch",   R, G, 2'b01, 3'd4, 1);
    clk_en = 1'b1;
    step(1);
    chk("ped_ew_yel",  R, Y, 2'b01, 3'd5, 1);
    step(4);
    chk("ped_allred",  R, R, 2'b00, 3'd0, 1);
    step(2);
    chk("ped_walk",    R, R, 2'b11, 3'd1, 0);
    ped = 1'b1;
    step(1);
    ped = 1'b0;
    chk("ped_in_walk", R, R, 2'b11, 3'd1, 0);
    step(13);
    chk("walk2_last",  R, R, 2'b11, 3'd1, 0);
    step(1);
    chk("walk2_exit",  R, R, 2'b00, 3'd0, 0);
    step(2);
    chk("tie_to_ns",   G, R, 2'b10, 3'd2, 0);

    // One enable in four: green still needs ten ticks before yielding.
    car_ew = 1'b1;
    for (int i = 0; i < 9; i++) en_tick();
    chk("div4_green",  G, R, 2'b10, 3'd2, 0);
    en_tick();
    chk("div4_yel",    Y, R, 2'b10, 3'd3, 0);
    en_tick();
    chk("div4_yel2",   Y, R, 2'b10, 3'd3, 0);

    // Asynchronous reset in the middle of NS yellow, between clock edges.
    #1 rst = 1'b1;
    #1;
    chk("rst_async",   R, R, 2'b00, 3'd0, 1);
    #1 rst = 1'b0;
    clk_en = 1'b1;
    car_ew = 1'b0;
    step(1);
    chk("rst_allred",  R, R, 2'b00, 3'd0, 1);
    step(1);
    chk("rst_walk",    R, R, 2'b11, 3'd1, 0);
    step(15);
    chk("rst_clr",     R, R, 2'b00, 3'd0, 0);
    step(2);
    chk("rst_ns",      G, R, 2'b10, 3'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tlc_param.md
Name: tlc_param

Overview:
- Parametrised second-generation traffic light controller for one NS/EW intersection with pedestrian scramble.
- Adds an internal phase timer with per-phase parametrised durations, so no external timer is needed.
- Adds latched pedestrian requests, all-red clearance, demand-driven direction choice and green rest/extension.
- Drives the lamp encodings from the shared tlc package; advances only on clk_en ticks.

Parameters:
- TW, 4, phase counter width in bits.
- T_ALLRED, 2, all-red clearance, in clk_en ticks.
- T_WALK, 15, pedestrian scramble (all cars red), in ticks.
- T_GREEN, 10, minimum green per direction, in ticks.
- T_YELLOW, 4, yellow per direction, in ticks.
- Elaboration check: every T_* must satisfy 1 <= T_* <= 2**TW.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clk_en  in  1  tick enable; the FSM and counter advance only when it is high
- car_ns  in  1  NS car present (level)
- car_ew  in  1  EW car present (level)
- ped  in  1  pedestrian request (pulse or level)
- light_ns  out  3  NS lamp (LIGHT_* encoding)
- light_ew  out  3  EW lamp
- light_ped  out  2  pedestrian lamp (PED_* encoding)
- phase  out  3  current state code (PH_* encoding), for debug/status
- ped_waiting  out  1  registered pedestrian request pending

Behaviour:
- One clock; reset is asynchronous and active-high.
- States: ALLRED, WALK, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW.
- Outputs are Moore, decoded from state only:
  - ALLRED: red/red, PED_NEITHER.
  - WALK: red/red, PED_BOTH.
  - NS_GREEN: green/red, PED_NS.
  - NS_YELLOW: yellow/red, PED_NS.
  - EW_GREEN and EW_YELLOW mirror the NS states with PED_EW.
- Reset values:
  - state = ALLRED, cnt = T_ALLRED-1, ped_pending = 1 (power-up scramble), last_dir = EW.
  - Outputs: red/red, PED_NEITHER, phase = 0, ped_waiting = 1.
- Counter:
  - On every state entry, cnt loads D-1, where D is the duration of the new state.
  - On clk_en with cnt != 0, cnt decrements.
  - A timed state therefore lasts exactly D clk_en ticks.
  - With clk_en low, state and cnt hold.
- Transitions are evaluated only on a clk_en edge with cnt == 0:
  - ALLRED -> WALK if ped_pending; otherwise -> green of the selected direction.
  - Direction selection: car_ns & !car_ew gives NS; car_ew & !car_ns gives EW; else the opposite of last_dir.
  - WALK -> ALLRED.
  - NS_GREEN -> NS_YELLOW if car_ew | ped_pending. Otherwise stay (rest in green; cnt stays 0; re-evaluated every tick).
  - EW_GREEN follows the same rule, with car_ns as the cross-street demand.
  - x_YELLOW -> ALLRED.
- last_dir updates on entry to either green.
- ped_pending:
  - Set on any clk edge with ped = 1, independent of clk_en, except while in WALK (ignored there).
  - Cleared on the tick that enters WALK.
  - Set and clear in the same edge: clear wins.
  - Decisions use the registered ped_pending, so a ped arriving on the deciding edge is served next cycle.
- Asynchronous reset mid-phase returns immediately to the reset state; the counter value is discarded.
- cnt arithmetic is unsigned TW bits. It is never decremented below 0 and never wraps.
- Unreachable state encodings decode to all-red/PED_NEITHER and go to ALLRED on the next tick.

Decomposition:
- tlc_pkg holds:
  - LIGHT_RED = 3'b100, LIGHT_YELLOW = 3'b010, LIGHT_GREEN = 3'b001.
  - PED_NEITHER = 2'b00, PED_EW = 2'b01, PED_NS = 2'b10, PED_BOTH = 2'b11.
  - state_t enum with PH_* codes: ALLRED = 0, WALK = 1, NS_GREEN = 2, NS_YELLOW = 3, EW_GREEN = 4, EW_YELLOW = 5.
- One sub-module, tlc_phase_timer (load/decrement/zero flag, TW wide), instantiated once.

Test Plan (defaults, clk_en held high, car inputs held per scenario):
- Reset, no cars, no ped:
  - ALLRED for 2 ticks, then WALK (PED_BOTH) for 15, then ALLRED for 2.
  - Then NS_GREEN (last_dir = EW); it rests while car_ew = 0.
  - ped_waiting = 0 from WALK entry onward.
- In NS_GREEN, assert car_ew after 3 ticks:
  - Green ends exactly at tick 10.
  - Then NS_YELLOW for 4 ticks, ALLRED for 2, then EW_GREEN.
- In NS_GREEN resting at 25 ticks, single-cycle ped pulse with clk_en low on that edge:
  - ped_waiting rises on the next edge.
  - Then NS_YELLOW 4, ALLRED 2, WALK 15, ALLRED 2, then NS_GREEN (tie, last_dir = NS gives EW? no: opposite gives EW_GREEN).
- ped pulse during WALK: ignored, ped_waiting stays 0, and the next ALLRED goes to a green.
- Toggle clk_en 1-in-4: all durations scale by 4 clocks; state is frozen between enables.
- Assert rst mid NS_YELLOW: outputs go red/red/PED_NEITHER asynchronously (same cycle), then the power-up scramble sequence repeats.
